// File: rtl/turn_scheduler_if.sv
// Signal bundle between the guess front end and the turn scheduler.
// The master drives player count, start and guesses. The slave reports turn, board and winner state.
interface turn_scheduler_if #(
    parameter int POS_W = 5
);
    logic [3:0]       N;
    logic             start;
    logic             B;
    logic             match;
    logic [1:0]       cur_player;
    logic [3:0]       p_da;
    logic [POS_W-1:0] p1_cnt;
    logic [POS_W-1:0] p2_cnt;
    logic [POS_W-1:0] p3_cnt;
    logic [POS_W-1:0] p4_cnt;
    logic             busy;
    logic             winner_vld;
    logic [1:0]       winner;
    logic             err;

    modport master (
        output N, start, B, match,
        input  cur_player, p_da, p1_cnt, p2_cnt, p3_cnt, p4_cnt,
               busy, winner_vld, winner, err
    );

    modport slave (
        input  N, start, B, match,
        output cur_player, p_da, p1_cnt, p2_cnt, p3_cnt, p4_cnt,
               busy, winner_vld, winner, err
    );
endinterface

// File: rtl/turn_scheduler.sv
// Turn controller for the 2-4 player ring board game.
// It keeps the player positions and turn order, moves or passes on each guess, and detects the winner.
module turn_scheduler #(
    parameter int BOARD_LEN = 24,
    parameter int POS_W     = 5
) (
    input  logic            clk,
    input  logic            rst,
    turn_scheduler_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_TURN,
        S_MOVE,
        S_SKIP,
        S_CHECK,
        S_NEXT,
        S_WIN
    } state_t;

    localparam logic [POS_W-1:0] LAST_POS   = POS_W'(BOARD_LEN - 1);
    localparam logic [POS_W-1:0] FULL_STEPS = POS_W'(BOARD_LEN);

    state_t           state_q, state_d;
    logic [3:0]       n_q, n_d;
    logic [1:0]       cur_q, cur_d;
    logic [1:0]       winner_q, winner_d;
    logic             err_q, err_d;
    logic             b_q;
    logic [POS_W-1:0] pos_q  [4];
    logic [POS_W-1:0] pos_d  [4];
    logic [POS_W-1:0] step_q [4];
    logic [POS_W-1:0] step_d [4];

    logic             b_edge;
    logic             busy;
    logic             occupied;
    logic [POS_W-1:0] next_pos;

    function automatic logic [POS_W-1:0] start_pos(input logic [3:0] n, input int idx);
        int spacing;
        case (n)
            4'd2:    spacing = BOARD_LEN / 2;
            4'd3:    spacing = BOARD_LEN / 3;
            4'd4:    spacing = BOARD_LEN / 4;
            default: spacing = 0;
        endcase
        if (idx >= int'(n)) return '0;
        return POS_W'(idx * spacing);
    endfunction

    assign b_edge = bus.B & ~b_q;
    assign busy   = (state_q == S_MOVE) || (state_q == S_SKIP);

    // Tile the current player would land on, and whether another active player already stands there.
    always_comb begin : tile_ahead
        next_pos = (pos_q[cur_q] == LAST_POS) ? '0 : pos_q[cur_q] + 1'b1;
        occupied = 1'b0;
        for (int j = 0; j < 4; j++) begin
            if ((2'(j) != cur_q) && (4'(j) < n_q) && (pos_q[j] == next_pos)) begin
                occupied = 1'b1;
            end
        end
    end

    always_comb begin : next_state
        // NOTE: every _d starts from its _q, so no branch of the case below can infer a latch.
        state_d  = state_q;
        n_d      = n_q;
        cur_d    = cur_q;
        winner_d = winner_q;
        err_d    = err_q;
        pos_d    = pos_q;
        step_d   = step_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    n_d = bus.N;
                    if (bus.N inside {4'd2, 4'd3, 4'd4}) begin
                        err_d   = 1'b0;
                        state_d = S_INIT;
                    end else begin
                        err_d   = 1'b1;
                    end
                end
            end
            S_INIT: begin
                for (int i = 0; i < 4; i++) begin
                    pos_d[i]  = start_pos(n_q, i);
                    step_d[i] = '0;
                end
                cur_d   = '0;
                state_d = S_TURN;
            end
            S_TURN: begin
                if (b_edge) state_d = bus.match ? S_MOVE : S_NEXT;
            end
            S_MOVE, S_SKIP: begin
                pos_d[cur_q] = next_pos;
                if (step_q[cur_q] < FULL_STEPS) step_d[cur_q] = step_q[cur_q] + 1'b1;
                state_d = occupied ? S_SKIP : S_CHECK;
            end
            S_CHECK: begin
                if (step_q[cur_q] >= FULL_STEPS) begin
                    winner_d = cur_q;
                    state_d  = S_WIN;
                end else begin
                    state_d  = S_TURN;
                end
            end
            S_NEXT: begin
                cur_d   = ({2'b00, cur_q} == n_q - 4'd1) ? 2'd0 : cur_q + 2'd1;
                state_d = S_TURN;
            end
            S_WIN: begin
                if (bus.start && !bus.B) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            n_q      <= '0;
            cur_q    <= '0;
            winner_q <= '0;
            err_q    <= 1'b0;
            b_q      <= 1'b0;
            // NOTE: the position and step arrays are small flop banks, not RAM, so they reset with the rest.
            for (int i = 0; i < 4; i++) begin
                pos_q[i]  <= '0;
                step_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            n_q      <= n_d;
            cur_q    <= cur_d;
            winner_q <= winner_d;
            err_q    <= err_d;
            b_q      <= bus.B;
            pos_q    <= pos_d;
            step_q   <= step_d;
        end
    end

    assign bus.busy       = busy;
    assign bus.p_da       = busy ? (4'b0001 << cur_q) : 4'b0000;
    assign bus.cur_player = cur_q;
    assign bus.p1_cnt     = pos_q[0];
    assign bus.p2_cnt     = pos_q[1];
    assign bus.p3_cnt     = pos_q[2];
    assign bus.p4_cnt     = pos_q[3];
    assign bus.winner_vld = (state_q == S_WIN);
    assign bus.winner     = winner_q;
    assign bus.err        = err_q;
endmodule

// File: tb/tb_turn_scheduler.sv
// Self-checking bench for turn_scheduler: directed scenarios followed by random games.
// All results are compared against a guess-level reference model of the game rules.
module tb_turn_scheduler;
    localparam int BOARD = 24;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    turn_scheduler_if bus_if ();

    turn_scheduler dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    // Reference model of the game, advanced once per guess.
    int m_pos   [4];
    int m_steps [4];
    int m_n, m_cur, m_winner;
    bit m_err, m_won, m_active;

    function automatic void model_reset();
        for (int i = 0; i < 4; i++) begin
            m_pos[i]   = 0;
            m_steps[i] = 0;
        end
        m_n = 0; m_cur = 0; m_winner = 0;
        m_err = 0; m_won = 0; m_active = 0;
    endfunction

    function automatic void model_start(input int n);
        m_won = 0;
        if (n >= 2 && n <= 4) begin
            m_n = n;
            for (int i = 0; i < 4; i++) begin
                m_pos[i]   = (i < n) ? (i * BOARD) / n : 0;
                m_steps[i] = 0;
            end
            m_cur = 0; m_err = 0; m_active = 1;
        end else begin
            m_err = 1; m_active = 0;
        end
    endfunction

    function automatic bit model_occupied(input int c);
        for (int j = 0; j < m_n; j++)
            if (j != c && m_pos[j] == m_pos[c]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic void model_guess(input bit m, output int pulses);
        pulses = 0;
        if (!m_active) return;
        if (m) begin
            do begin
                m_pos[m_cur] = (m_pos[m_cur] + 1) % BOARD;
                if (m_steps[m_cur] < BOARD) m_steps[m_cur]++;
                pulses++;
            end while (model_occupied(m_cur));
            if (m_steps[m_cur] >= BOARD) begin
                m_won = 1; m_winner = m_cur; m_active = 0;
            end
        end else begin
            m_cur = (m_cur + 1) % m_n;
        end
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".cur_player"}, 32'(bus_if.cur_player), m_cur);
        check({tag, ".p1_cnt"},     32'(bus_if.p1_cnt),     m_pos[0]);
        check({tag, ".p2_cnt"},     32'(bus_if.p2_cnt),     m_pos[1]);
        check({tag, ".p3_cnt"},     32'(bus_if.p3_cnt),     m_pos[2]);
        check({tag, ".p4_cnt"},     32'(bus_if.p4_cnt),     m_pos[3]);
        check({tag, ".err"},        32'(bus_if.err),        32'(m_err));
        check({tag, ".winner_vld"}, 32'(bus_if.winner_vld), 32'(m_won));
        check({tag, ".winner"},     32'(bus_if.winner),     m_winner);
        check({tag, ".busy"},       32'(bus_if.busy),       0);
        check({tag, ".p_da"},       32'(bus_if.p_da),       0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    // hold = cycles start stays high (2 when leaving WIN, 1 from IDLE).
    task automatic start_game(input int n, input int hold);
        @(negedge clk);
        bus_if.N     = 4'(n);
        bus_if.start = 1'b1;
        repeat (hold) @(negedge clk);
        bus_if.start = 1'b0;
        repeat (2) @(negedge clk);
        model_start(n);
    endtask

    // One B edge with the given match; samples six cycles, which covers MOVE, three SKIPs, CHECK and TURN.
    task automatic guess(input bit m, input bit inject, output int pulses, output int busy_n);
        int       exp_pulses, first_p, last_p, bad;
        bit       act;
        logic [3:0] exp_bit;
        act     = m_active;
        exp_bit = 4'(1 << m_cur);
        pulses = 0; busy_n = 0; first_p = -1; last_p = -1; bad = 0;
        @(negedge clk);
        bus_if.B     = 1'b1;
        bus_if.match = m;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k == 0) begin
                bus_if.B = 1'b0;
                check("first_pulse", 32'(bus_if.p_da), (m && act) ? 32'(exp_bit) : 0);
            end
            if (bus_if.p_da == exp_bit) begin
                pulses++;
                if (first_p < 0) first_p = k;
                last_p = k;
            end else if (bus_if.p_da != 4'd0) begin
                bad++;
            end
            if (bus_if.busy) busy_n++;
            if (bus_if.busy !== (bus_if.p_da != 4'd0)) bad++;
            if (inject && k == 1) begin
                check("inject_while_busy", 32'(bus_if.busy), 1);
                bus_if.B = 1'b1;
            end
            if (inject && k == 2) bus_if.B = 1'b0;
        end
        model_guess(m, exp_pulses);
        check("pulse_count", pulses, exp_pulses);
        if (pulses > 0 && (last_p - first_p + 1) != pulses) bad++;
        check("pulse_shape", bad, 0);
        check_all("after_guess");
    endtask

    initial begin
        int pulses, busy_n, n, guesses;
        bit m;
        bus_if.N = '0; bus_if.start = 1'b0; bus_if.B = 1'b0; bus_if.match = 1'b0;
        model_reset();

        // Reset values, then a three-player game.
        repeat (2) @(negedge clk);
        check_all("reset");
        rst = 1'b0;
        start_game(3, 1);
        check_all("init_n3");
        check("init_n3.p2_const", 32'(bus_if.p2_cnt), 8);
        check("init_n3.p3_const", 32'(bus_if.p3_cnt), 16);

        // Two players: a correct guess moves, a wrong guess passes the turn.
        do_reset();
        start_game(2, 1);
        guess(1'b1, 1'b0, pulses, busy_n);
        check("n2_move.p1_const", 32'(bus_if.p1_cnt), 1);
        check("n2_move.pulses", pulses, 1);
        check("n2_move.cur", 32'(bus_if.cur_player), 0);
        guess(1'b0, 1'b0, pulses, busy_n);
        check("n2_pass.cur", 32'(bus_if.cur_player), 1);
        check("n2_pass.pulses", pulses, 0);

        // Player 2 goes round the ring, wraps 23 -> 0 (skipping p1 on 0) and wins on step 24.
        do_reset();
        start_game(2, 1);
        guess(1'b0, 1'b0, pulses, busy_n);
        for (int g = 0; g < 11; g++) guess(1'b1, 1'b0, pulses, busy_n);
        check("wrap.p2_at_23", 32'(bus_if.p2_cnt), 23);
        guess(1'b1, 1'b0, pulses, busy_n);
        check("wrap.p2_skips_0", 32'(bus_if.p2_cnt), 1);
        check("wrap.pulses", pulses, 2);
        for (int g = 0; g < 11; g++) guess(1'b1, 1'b0, pulses, busy_n);
        check("win.vld", 32'(bus_if.winner_vld), 1);
        check("win.winner", 32'(bus_if.winner), 1);
        guess(1'b1, 1'b0, pulses, busy_n);
        check("win.ignored_pulses", pulses, 0);

        // An illegal N leaving WIN sets err; B is then ignored in IDLE; a legal N clears err.
        start_game(5, 2);
        check("bad_n.err", 32'(bus_if.err), 1);
        guess(1'b1, 1'b0, pulses, busy_n);
        check("bad_n.idle_pulses", pulses, 0);
        start_game(4, 1);
        check("good_n.err", 32'(bus_if.err), 0);
        check("good_n.p4_const", 32'(bus_if.p4_cnt), 18);

        // p1 at 5 with p2 on 6: one skip onto 7, two pulses and two busy cycles.
        for (int g = 0; g < 5; g++) guess(1'b1, 1'b0, pulses, busy_n);
        check("skip.p1_at_5", 32'(bus_if.p1_cnt), 5);
        guess(1'b1, 1'b0, pulses, busy_n);
        check("skip.p1_const", 32'(bus_if.p1_cnt), 7);
        check("skip.pulses", pulses, 2);
        check("skip.busy_cycles", busy_n, 2);

        // A B edge during SKIP must be dropped, not replayed.
        for (int g = 0; g < 4; g++) guess(1'b1, 1'b0, pulses, busy_n);
        guess(1'b1, 1'b1, pulses, busy_n);
        check("inject.p1_const", 32'(bus_if.p1_cnt), 13);
        check("inject.pulses", pulses, 2);

        // Reset while in SKIP (p1 moving onto p4's tile 18) clears everything immediately.
        for (int g = 0; g < 4; g++) guess(1'b1, 1'b0, pulses, busy_n);
        @(negedge clk);
        bus_if.B = 1'b1; bus_if.match = 1'b1;
        @(negedge clk);
        bus_if.B = 1'b0;
        check("rst_skip.move_busy", 32'(bus_if.busy), 1);
        @(negedge clk);
        check("rst_skip.skip_busy", 32'(bus_if.busy), 1);
        check("rst_skip.skip_pda", 32'(bus_if.p_da), 1);
        #2 rst = 1'b1;
        #1 model_reset();
        check_all("async_reset");
        @(negedge clk);
        rst = 1'b0;

        // Random games played to completion against the model.
        for (int gm = 0; gm < 3; gm++) begin
            do_reset();
            n = $urandom_range(2, 4);
            start_game(n, 1);
            check_all("rand_init");
            guesses = 0;
            while (!m_won && guesses < 400) begin
                m = ($urandom_range(0, 99) < 70);
                guess(m, 1'b0, pulses, busy_n);
                guesses++;
            end
            check("rand.game_finished", 32'(bus_if.winner_vld), 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
